// File: rtl/mpt2042_spi_defs.sv
// Definitions shared by both ends of the MPT2042 SPI link: FSM encoding,
// default bus mode and word size, and synchronizer depth.
package mpt2042_spi_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_END   = 2'd3
    } spi_state_e;

    localparam logic       DEF_SPI_CPOL = 1'b0;
    localparam logic       DEF_SPI_CPHA = 1'b1;
    localparam logic [3:0] DEF_BIT_NUM  = 4'd8;
    localparam int         SYNC_STAGES  = 2;

    // Keeps only the low bit_num bits of a received byte.
    function automatic logic [7:0] byte_mask(input logic [3:0] bit_num);
        return 8'hFF >> (4'd8 - bit_num);
    endfunction

endpackage

// File: rtl/mpt2042_spi_slave_if.sv
// SPI pins plus the byte-level handshake of the MPT2042 SPI slave.
interface mpt2042_spi_slave_if;

    logic       i_spi_cs_n;
    logic       i_spi_dclk;
    logic       i_spi_mosi;
    logic       o_spi_miso;
    logic [7:0] i_tx_byte;
    logic       o_tx_taken;
    logic [7:0] o_rx_byte;
    logic       o_rx_valid;
    logic       o_frame_err;

    modport slave (
        input  i_spi_cs_n, i_spi_dclk, i_spi_mosi, i_tx_byte,
        output o_spi_miso, o_tx_taken, o_rx_byte, o_rx_valid, o_frame_err
    );

    modport master (
        output i_spi_cs_n, i_spi_dclk, i_spi_mosi, i_tx_byte,
        input  o_spi_miso, o_tx_taken, o_rx_byte, o_rx_valid, o_frame_err
    );

endinterface

// File: rtl/mpt2042_sync_2ff.sv
// Two-stage synchronizer for a single asynchronous input, with a
// configurable reset level so the idle state is seen right after reset.
module mpt2042_sync_2ff
    import mpt2042_spi_defs::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] sync_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_reg <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/mpt2042_spi_slave.sv
// Oversampling SPI slave: pins are synchronized to i_clk and DCLK edges are
// detected in-domain. Define MPT2042_SPIS_FRAME_ERR_EN to enable o_frame_err.
module mpt2042_spi_slave
    import mpt2042_spi_defs::*;
#(
    parameter logic       SPI_CPOL = DEF_SPI_CPOL,
    parameter logic       SPI_CPHA = DEF_SPI_CPHA,
    parameter logic [3:0] BIT_NUM  = DEF_BIT_NUM
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    mpt2042_spi_slave_if.slave bus
);

    localparam int         MSB_IDX  = int'(BIT_NUM) - 1;
    localparam logic [3:0] LAST_BIT = BIT_NUM - 4'd1;
    localparam logic [7:0] RX_MASK  = byte_mask(BIT_NUM);
    // Reset levels per synchronized pin, ordered {mosi, dclk, cs_n}.
    localparam logic [2:0] SYNC_RST = {1'b0, SPI_CPOL, 1'b1};

    logic [2:0] pin_in;
    logic [2:0] pin_sync;
    logic       cs_sync;
    logic       dclk_sync;
    logic       mosi_sync;

    assign pin_in = {bus.i_spi_mosi, bus.i_spi_dclk, bus.i_spi_cs_n};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            mpt2042_sync_2ff #(
                .RST_VAL (SYNC_RST[gi])
            ) u_sync (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_d     (pin_in[gi]),
                .o_q     (pin_sync[gi])
            );
        end
    endgenerate

    assign cs_sync   = pin_sync[0];
    assign dclk_sync = pin_sync[1];
    assign mosi_sync = pin_sync[2];

    logic       cs_d_reg;
    logic       dclk_d_reg;
    logic [1:0] flush_cnt_reg;
    logic       armed_reg;

    // A CS already low when reset lifts must not start a transfer, so the
    // falling-edge detector is armed only once CS has been seen high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cs_d_reg      <= 1'b1;
            dclk_d_reg    <= SPI_CPOL;
            flush_cnt_reg <= 2'd0;
            armed_reg     <= 1'b0;
        end else begin
            cs_d_reg   <= cs_sync;
            dclk_d_reg <= dclk_sync;
            if (flush_cnt_reg != 2'd3) begin
                flush_cnt_reg <= flush_cnt_reg + 2'd1;
            end else if (cs_d_reg) begin
                armed_reg <= 1'b1;
            end
        end
    end

    logic cs_fall;
    logic cs_rise;
    logic lead_ev;
    logic trail_ev;
    logic sample_ev;
    logic shift_ev;

    assign cs_fall   = armed_reg & cs_d_reg & ~cs_sync;
    assign cs_rise   = ~cs_d_reg & cs_sync;
    assign lead_ev   = (dclk_d_reg == SPI_CPOL) && (dclk_sync != SPI_CPOL);
    assign trail_ev  = (dclk_d_reg != SPI_CPOL) && (dclk_sync == SPI_CPOL);
    assign sample_ev = (SPI_CPHA ? trail_ev : lead_ev) && !cs_sync;
    assign shift_ev  = (SPI_CPHA ? lead_ev : trail_ev) && !cs_sync;

    spi_state_e state_reg;
    spi_state_e state_next;
    logic [3:0] bit_cnt_reg;
    logic       load_en;
    logic       sample_en;
    logic       shift_en;
    logic       byte_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (cs_rise) begin
            state_next = ST_END;
        end else begin
            case (state_reg)
                ST_IDLE:  if (cs_fall) state_next = ST_LOAD;
                ST_LOAD:  state_next = ST_SHIFT;
                ST_SHIFT: state_next = ST_SHIFT;
                ST_END:   state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        load_en   = 1'b0;
        sample_en = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        case (state_reg)
            ST_LOAD: load_en = !cs_rise;
            ST_SHIFT: begin
                sample_en = sample_ev;
                shift_en  = shift_ev;
                byte_done = sample_ev && (bit_cnt_reg == LAST_BIT);
            end
            default: ;
        endcase
    end

    logic [6:0] rx_shift_reg;
    logic [7:0] rx_word;
    logic [7:0] rx_byte_reg;
    logic [7:0] tx_shift_reg;
    logic       miso_reg;
    logic       rx_valid_reg;
    logic       tx_taken_reg;

    assign rx_word = {rx_shift_reg, mosi_sync};

    // tx_shift_reg holds the bits not yet presented; each shift edge drives
    // its MSB. With CPHA=0 the first bit must already be out before the
    // first sample edge, so the load presents it directly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt_reg  <= 4'd0;
            rx_shift_reg <= 7'd0;
            rx_byte_reg  <= 8'h00;
            tx_shift_reg <= 8'h00;
            miso_reg     <= 1'b0;
            rx_valid_reg <= 1'b0;
            tx_taken_reg <= 1'b0;
        end else begin
            rx_valid_reg <= byte_done;
            tx_taken_reg <= load_en | byte_done;
            if (state_next == ST_IDLE || state_next == ST_END) begin
                bit_cnt_reg <= 4'd0;
                miso_reg    <= 1'b0;
            end else if (load_en) begin
                bit_cnt_reg  <= 4'd0;
                rx_shift_reg <= 7'd0;
                tx_shift_reg <= SPI_CPHA ? bus.i_tx_byte : (bus.i_tx_byte << 1);
                miso_reg     <= SPI_CPHA ? 1'b0 : bus.i_tx_byte[MSB_IDX];
            end else begin
                if (sample_en) begin
                    rx_shift_reg <= rx_word[6:0];
                    bit_cnt_reg  <= byte_done ? 4'd0 : bit_cnt_reg + 4'd1;
                    if (byte_done) begin
                        rx_byte_reg  <= rx_word & RX_MASK;
                        tx_shift_reg <= bus.i_tx_byte;
                    end
                end
                if (shift_en) begin
                    miso_reg     <= tx_shift_reg[MSB_IDX];
                    tx_shift_reg <= tx_shift_reg << 1;
                end
            end
        end
    end

    assign bus.o_spi_miso = miso_reg;
    assign bus.o_rx_byte  = rx_byte_reg;
    assign bus.o_rx_valid = rx_valid_reg;
    assign bus.o_tx_taken = tx_taken_reg;

`ifdef MPT2042_SPIS_FRAME_ERR_EN
    logic frame_err_reg;

    // Registered on the CS-rise cycle so the pulse coincides with ST_END.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= cs_rise && (bit_cnt_reg != 4'd0);
        end
    end

    assign bus.o_frame_err = frame_err_reg;
`else
    assign bus.o_frame_err = 1'b0;
`endif

endmodule

// File: doc/mpt2042_spi_slave.md
MPT2042_SPI_SLAVE -- requirements
Module: mpt2042_spi_slave

Interface
REQ-001 SHALL have parameter SPI_CPOL, default 1'b0, idle level of DCLK.
REQ-002 SHALL have parameter SPI_CPHA, default 1'b1, sample on trailing edge (1) or leading edge (0).
REQ-003 SHALL have parameter BIT_NUM, default 4'd8, bits per byte, MSB first.
REQ-004 SHALL have port i_clk, input, 1, single system clock; all logic on rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports i_spi_cs_n, i_spi_dclk and i_spi_mosi, each an input of width 1: chip select (active low), serial clock and master data, all asynchronous to i_clk.
REQ-007 SHALL have port o_spi_miso, output, 1, slave data.
REQ-008 SHALL have port i_tx_byte, input, [7:0], next byte to return to the master.
REQ-009 SHALL have port o_tx_taken, output, 1, one-cycle pulse when i_tx_byte is captured.
REQ-010 SHALL have port o_rx_byte, output, [7:0], last complete received byte.
REQ-011 SHALL have port o_rx_valid, output, 1, one-cycle pulse when o_rx_byte updates.
REQ-012 SHALL have port o_frame_err, output, 1, one-cycle pulse on an aborted byte.

Function
REQ-013 SHALL pass i_spi_cs_n, i_spi_dclk and i_spi_mosi through 2-FF synchronizers, and SHALL detect edges by comparing the second stage against a third registered stage.
REQ-014 SHALL define the leading edge as DCLK leaving SPI_CPOL and the trailing edge as DCLK returning to SPI_CPOL.
REQ-015 SHALL sample MOSI on the trailing edge when SPI_CPHA=1 and on the leading edge when SPI_CPHA=0; the shift edge is the opposite edge.
REQ-016 SHALL implement FSM states ST_IDLE, ST_LOAD, ST_SHIFT and ST_END, with a one-hot-free binary encoding.
REQ-017 ST_IDLE -> ST_LOAD on a synchronized CS falling edge; a CS that is already low at reset release SHALL be ignored until CS goes high.
REQ-018 ST_LOAD SHALL last one cycle: capture i_tx_byte, pulse o_tx_taken, clear the bit counter, drive the MSB on o_spi_miso when SPI_CPHA=0, then go to ST_SHIFT.
REQ-019 In ST_SHIFT, each sample edge SHALL shift the MOSI bit into the rx register LSB and increment the bit counter.
REQ-020 In ST_SHIFT, each shift edge SHALL present the next tx bit on o_spi_miso; with SPI_CPHA=1 the first leading edge SHALL present the MSB.
REQ-021 At sample number BIT_NUM, the block SHALL wrap the counter to 0, update o_rx_byte, pulse o_rx_valid, re-capture i_tx_byte and pulse o_tx_taken in the same cycle.
REQ-022 Multi-byte frames SHALL continue without a gap until CS rises.
REQ-023 o_rx_valid SHALL rise on the 3rd i_clk rising edge after the final sampling edge at the pin.
REQ-024 A synchronized CS rising edge in any state SHALL go to ST_END, which SHALL last one cycle and then return to ST_IDLE.
REQ-025 If the bit counter is nonzero when CS rises, the partial byte SHALL be discarded with no o_rx_valid.
REQ-026 DCLK edges while CS is high SHALL be ignored.
REQ-027 o_spi_miso SHALL be 1'b0 in ST_IDLE.
REQ-028 Correct operation SHALL require each DCLK level to be held for at least 4 i_clk cycles, i.e. master CLK_DIV_NUM >= 8.

Reset
REQ-029 While i_rst_n is low, the block SHALL hold the state in ST_IDLE and hold o_spi_miso, o_rx_valid, o_tx_taken and o_frame_err at 0.
REQ-030 While i_rst_n is low, o_rx_byte and all shift registers SHALL be 8'h00, the bit counter SHALL be 0, and the synchronizers SHALL hold cs=1 and dclk=SPI_CPOL.
REQ-031 A reset asserted mid-byte SHALL abort the transfer immediately, with no o_rx_valid and no o_frame_err.

Configuration
REQ-032 With MPT2042_SPIS_FRAME_ERR_EN defined, a CS rise with a nonzero bit counter SHALL pulse o_frame_err for one cycle during ST_END; without the macro, o_frame_err SHALL be tied to 0 and the detection logic SHALL be absent.

Structure
REQ-033 The state encodings, the default SPI_CPOL/SPI_CPHA/BIT_NUM values and the synchronizer depth SHALL live in a shared mpt2042_spi_defs package/include file used by both SPI ends.
REQ-034 A single sub-module, mpt2042_sync_2ff, SHALL be instantiated once per asynchronous input.

Verification
REQ-035 Mode 1, CLK_DIV 8, i_tx_byte=8'hA5, master sends 8'h3C: o_rx_byte=8'h3C with one o_rx_valid pulse, and the master reads 8'hA5.
REQ-036 Run all four modes back-to-back with MOSI 8'h81 and MISO 8'h7E; every mode SHALL return the correct bytes both ways.
REQ-037 A 3-byte frame 8'h01, 8'h02, 8'h03 with i_tx_byte changing on each o_tx_taken SHALL produce 3 o_rx_valid pulses, 4 o_tx_taken pulses and ordered MISO data.
REQ-038 CS rising after 5 bits SHALL produce no o_rx_valid; o_frame_err SHALL be 1 for one cycle with the macro and 0 without it.
REQ-039 i_rst_n pulsed low mid-byte with CS held low SHALL hold all outputs at 0 and ignore DCLK until CS toggles high then low, after which the next byte SHALL be received correctly.
